// File: rtl/vga_matrix_pkg.sv
// rtl/vga_matrix_pkg.sv - shared VGA visible-window and game-matrix constants
// Contents: visible raster window, matrix geometry, address/index widths.
package vga_matrix_pkg;

    localparam int H_W     = 11;
    localparam int V_W     = 10;
    localparam int IDX_X_W = 7;
    localparam int IDX_Y_W = 6;
    localparam int SUB_W   = 4;
    localparam int ADDR_W  = 12;

    localparam logic [H_W-1:0] H_VISIBLE_START = 11'd336;
    localparam logic [H_W-1:0] H_VISIBLE_END   = 11'd1615;
    localparam logic [V_W-1:0] V_VISIBLE_START = 10'd27;
    localparam logic [V_W-1:0] V_VISIBLE_END   = 10'd826;

    localparam int MATRIX_W   = 80;
    localparam int MATRIX_H   = 50;
    localparam int CELL_SHIFT = 4;

    // Row stride as an address-width constant so the row_base step is a plain add.
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(MATRIX_W);

endpackage

// File: rtl/display_to_matrix_idx_if.sv
// rtl/display_to_matrix_idx_if.sv - raster-in / matrix-index-out bundle
// master: raster source side (drives h_count/v_count, receives indices).
// slave : mapper side (receives raster, drives rd_en/rd_addr and stage-2 indices).
interface display_to_matrix_idx_if;
    import vga_matrix_pkg::*;

    logic [H_W-1:0]     h_count;
    logic [V_W-1:0]     v_count;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic               valid;
    logic [IDX_X_W-1:0] idx_x;
    logic [IDX_Y_W-1:0] idx_y;
    logic [SUB_W-1:0]   sub_x;
    logic [SUB_W-1:0]   sub_y;
    logic               frame_start;
    logic               sync_err;

    modport master (
        output h_count, v_count,
        input  rd_en, rd_addr, valid, idx_x, idx_y, sub_x, sub_y, frame_start, sync_err
    );

    modport slave (
        input  h_count, v_count,
        output rd_en, rd_addr, valid, idx_x, idx_y, sub_x, sub_y, frame_start, sync_err
    );

endinterface

// File: rtl/display_to_matrix_idx_row_tracker.sv
// rtl/display_to_matrix_idx_row_tracker.sv - line-start driven cell-row tracker
// Ports: clk, rst_n (async active-low), line_start (h_count at first visible column),
//        v_count; row/sub_y/row_base are the post-update values for the current cycle
//        (combinational on a line-start cycle, registered otherwise); sync_err sticky.
module matrix_row_tracker
    import vga_matrix_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               line_start,
    input  logic [V_W-1:0]     v_count,
    output logic [IDX_Y_W-1:0] row,
    output logic [SUB_W-1:0]   sub_y,
    output logic [ADDR_W-1:0]  row_base,
    output logic               sync_err
);

    logic [IDX_Y_W-1:0] row_q,  row_d;
    logic [SUB_W-1:0]   sub_q,  sub_d;
    logic [ADDR_W-1:0]  base_q, base_d;
    logic               err_q,  err_d;
    logic               mismatch;
    logic               first_line;
    logic               line_vis;
    logic [V_W-1:0]     vy;

    assign vy         = v_count - V_VISIBLE_START;
    assign line_vis   = (v_count >= V_VISIBLE_START) && (v_count <= V_VISIBLE_END);
    assign first_line = line_start && (v_count == V_VISIBLE_START);

    always_comb begin
        row_d    = row_q;
        sub_d    = sub_q;
        base_d   = base_q;
        mismatch = 1'b0;
        if (first_line) begin
            row_d  = '0;
            sub_d  = '0;
            base_d = '0;
        end else if (line_start && line_vis) begin
            sub_d = sub_q + 4'd1;
            if (sub_q == 4'hF) begin
                row_d  = row_q + 6'd1;
                base_d = base_q + ROW_STRIDE;
            end
            // Raster jumped (or tracker started mid-frame): rebuild from v_count.
            // row*80 is formed as row*64 + row*16 to stay multiplier-free.
            if ({row_d, sub_d} != vy) begin
                mismatch = 1'b1;
                row_d    = vy[9:4];
                sub_d    = vy[3:0];
                base_d   = {vy[9:4], 6'b0} + {2'b0, vy[9:4], 4'b0};
            end
        end
    end

    // A detected mismatch wins over the frame-start clear.
    always_comb begin
        err_d = err_q;
        if (mismatch)        err_d = 1'b1;
        else if (first_line) err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q  <= '0;
            sub_q  <= '0;
            base_q <= '0;
            err_q  <= 1'b0;
        end else begin
            row_q  <= row_d;
            sub_q  <= sub_d;
            base_q <= base_d;
            err_q  <= err_d;
        end
    end

    assign row      = row_d;
    assign sub_y    = sub_d;
    assign row_base = base_d;
    assign sync_err = err_q;

endmodule

// File: rtl/display_to_matrix_idx.sv
// rtl/display_to_matrix_idx.sv - VGA raster position to 80x50 matrix cell/offset/address
// Ports: clk, rst_n (async active-low), bus (slave): h_count/v_count in;
//        rd_en/rd_addr at stage 1; valid/idx_x/idx_y/sub_x/sub_y/frame_start at stage 2;
//        sync_err sticky row-tracker error.
module display_to_matrix_idx
    import vga_matrix_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    display_to_matrix_idx_if.slave bus
);

    logic [H_W-1:0]     hx;
    logic               h_vis, v_vis, visible, line_start;
    logic [IDX_X_W-1:0] col_raw;
    logic [IDX_Y_W-1:0] trk_row;
    logic [SUB_W-1:0]   trk_sub_y;
    logic [ADDR_W-1:0]  trk_base;
    logic               trk_err;

    logic [ADDR_W-1:0]  addr_c;
    logic [IDX_X_W-1:0] idx_x_c;
    logic [IDX_Y_W-1:0] idx_y_c;
    logic [SUB_W-1:0]   sub_x_c, sub_y_c;
    logic               fs_c;

    // Column decode is stateless, so h_count jumps inside a line are harmless.
    assign hx         = bus.h_count - H_VISIBLE_START;
    assign h_vis      = (bus.h_count >= H_VISIBLE_START) && (bus.h_count <= H_VISIBLE_END);
    assign v_vis      = (bus.v_count >= V_VISIBLE_START) && (bus.v_count <= V_VISIBLE_END);
    assign visible    = h_vis && v_vis;
    assign line_start = (bus.h_count == H_VISIBLE_START);
    assign col_raw    = hx[H_W-1:CELL_SHIFT];

    matrix_row_tracker u_row_tracker (
        .clk        (clk),
        .rst_n      (rst_n),
        .line_start (line_start),
        .v_count    (bus.v_count),
        .row        (trk_row),
        .sub_y      (trk_sub_y),
        .row_base   (trk_base),
        .sync_err   (trk_err)
    );

    assign addr_c  = visible ? (trk_base + {5'b0, col_raw}) : '0;
    assign idx_x_c = visible ? col_raw : '0;
    assign idx_y_c = visible ? trk_row : '0;
    assign sub_x_c = visible ? hx[CELL_SHIFT-1:0] : '0;
    assign sub_y_c = visible ? trk_sub_y : '0;
    assign fs_c    = visible && line_start && (bus.v_count == V_VISIBLE_START);

    // Stage 1: RAM request plus the cell fields held back one cycle to meet RAM data.
    logic               s1_rd_en;
    logic [ADDR_W-1:0]  s1_rd_addr;
    logic [IDX_X_W-1:0] s1_idx_x;
    logic [IDX_Y_W-1:0] s1_idx_y;
    logic [SUB_W-1:0]   s1_sub_x, s1_sub_y;
    logic               s1_fs;

    // Stage 2: outputs aligned with RAM read data.
    logic               s2_valid;
    logic [IDX_X_W-1:0] s2_idx_x;
    logic [IDX_Y_W-1:0] s2_idx_y;
    logic [SUB_W-1:0]   s2_sub_x, s2_sub_y;
    logic               s2_fs;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_rd_en   <= 1'b0;
            s1_rd_addr <= '0;
            s1_idx_x   <= '0;
            s1_idx_y   <= '0;
            s1_sub_x   <= '0;
            s1_sub_y   <= '0;
            s1_fs      <= 1'b0;
            s2_valid   <= 1'b0;
            s2_idx_x   <= '0;
            s2_idx_y   <= '0;
            s2_sub_x   <= '0;
            s2_sub_y   <= '0;
            s2_fs      <= 1'b0;
        end else begin
            s1_rd_en   <= visible;
            s1_rd_addr <= addr_c;
            s1_idx_x   <= idx_x_c;
            s1_idx_y   <= idx_y_c;
            s1_sub_x   <= sub_x_c;
            s1_sub_y   <= sub_y_c;
            s1_fs      <= fs_c;
            s2_valid   <= s1_rd_en;
            s2_idx_x   <= s1_idx_x;
            s2_idx_y   <= s1_idx_y;
            s2_sub_x   <= s1_sub_x;
            s2_sub_y   <= s1_sub_y;
            s2_fs      <= s1_fs;
        end
    end

    assign bus.rd_en       = s1_rd_en;
    assign bus.rd_addr     = s1_rd_addr;
    assign bus.valid       = s2_valid;
    assign bus.idx_x       = s2_idx_x;
    assign bus.idx_y       = s2_idx_y;
    assign bus.sub_x       = s2_sub_x;
    assign bus.sub_y       = s2_sub_y;
    assign bus.frame_start = s2_fs;
    assign bus.sync_err    = trk_err;

endmodule

// File: tb/tb_display_to_matrix_idx.sv
// tb/tb_display_to_matrix_idx.sv - directed bench for display_to_matrix_idx
module tb_display_to_matrix_idx;

    typedef struct {
        int vis;
        int ix;
        int iy;
        int sx;
        int sy;
        int addr;
        int fs;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   exp_serr;
    bit   auto_chk;
    exp_t prev;

    display_to_matrix_idx_if bus ();

    display_to_matrix_idx dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Reference mapping by plain divide/modulo.
    task automatic model(input int h, input int v, output exp_t e);
        e = '{default: 0};
        if (h >= 336 && h <= 1615 && v >= 27 && v <= 826) begin
            e.vis  = 1;
            e.ix   = (h - 336) / 16;
            e.sx   = (h - 336) % 16;
            e.iy   = (v - 27) / 16;
            e.sy   = (v - 27) % 16;
            e.addr = e.iy * 80 + e.ix;
            e.fs   = (h == 336 && v == 27) ? 1 : 0;
        end
    endtask

    task automatic step(input int h, input int v);
        exp_t e;
        if (h == 336 && v == 27) exp_serr = 0;
        bus.h_count = 11'(h);
        bus.v_count = 10'(v);
        model(h, v, e);
        @(posedge clk);
        #1;
        if (auto_chk) begin
            chk("s1_rd_en",   32'(bus.rd_en),       32'(e.vis));
            chk("s1_rd_addr", 32'(bus.rd_addr),     32'(e.addr));
            chk("s2_valid",   32'(bus.valid),       32'(prev.vis));
            chk("s2_idx_x",   32'(bus.idx_x),       32'(prev.ix));
            chk("s2_idx_y",   32'(bus.idx_y),       32'(prev.iy));
            chk("s2_sub_x",   32'(bus.sub_x),       32'(prev.sx));
            chk("s2_sub_y",   32'(bus.sub_y),       32'(prev.sy));
            chk("s2_fs",      32'(bus.frame_start), 32'(prev.fs));
            chk("sync_err",   32'(bus.sync_err),    32'(exp_serr));
        end
        prev = e;
    endtask

    task automatic run_line(input int v);
        step(0, v);
        step(336, v);
        step(337, v);
        step(351, v);
        step(352, v);
        step(int'($urandom_range(353, 1614)), v);
        step(1615, v);
        step(1616, v);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_rd_en"},   32'(bus.rd_en),       0);
        chk({tag, "_rd_addr"}, 32'(bus.rd_addr),     0);
        chk({tag, "_valid"},   32'(bus.valid),       0);
        chk({tag, "_idx_x"},   32'(bus.idx_x),       0);
        chk({tag, "_idx_y"},   32'(bus.idx_y),       0);
        chk({tag, "_sub_x"},   32'(bus.sub_x),       0);
        chk({tag, "_sub_y"},   32'(bus.sub_y),       0);
        chk({tag, "_fs"},      32'(bus.frame_start), 0);
        chk({tag, "_serr"},    32'(bus.sync_err),    0);
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        exp_serr    = 0;
        auto_chk    = 1'b0;
        prev        = '{default: 0};
        rst_n       = 1'b0;
        bus.h_count = '0;
        bus.v_count = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n    = 1'b1;
        auto_chk = 1'b1;

        // Frame 1 with directed points, then two more plain frames
        for (int v = 0; v < 830; v++) begin
            if (v == 27) begin
                step(0, 27);
                step(335, 27);
                step(336, 27);
                chk("fs_rd_en", 32'(bus.rd_en), 1);
                chk("fs_rd_addr", 32'(bus.rd_addr), 0);
                step(337, 27);
                chk("fs_valid", 32'(bus.valid), 1);
                chk("fs_idx_x", 32'(bus.idx_x), 0);
                chk("fs_idx_y", 32'(bus.idx_y), 0);
                chk("fs_sub_x", 32'(bus.sub_x), 0);
                chk("fs_sub_y", 32'(bus.sub_y), 0);
                chk("fs_pulse", 32'(bus.frame_start), 1);
                chk("fs_serr", 32'(bus.sync_err), 0);
                step(338, 27);
                chk("fs_pulse_end", 32'(bus.frame_start), 0);
                step(1616, 27);
            end else if (v == 42) begin
                step(0, 42);
                step(336, 42);
                step(351, 42);
                chk("p351_rd_addr", 32'(bus.rd_addr), 0);
                step(352, 42);
                chk("p351_idx_x", 32'(bus.idx_x), 0);
                chk("p351_idx_y", 32'(bus.idx_y), 0);
                chk("p351_sub_x", 32'(bus.sub_x), 15);
                chk("p351_sub_y", 32'(bus.sub_y), 15);
                step(1616, 42);
            end else if (v == 43) begin
                step(0, 43);
                step(336, 43);
                step(352, 43);
                chk("p352_rd_addr", 32'(bus.rd_addr), 81);
                step(1616, 43);
                chk("p352_idx_x", 32'(bus.idx_x), 1);
                chk("p352_idx_y", 32'(bus.idx_y), 1);
                chk("p352_sub_x", 32'(bus.sub_x), 0);
                chk("p352_sub_y", 32'(bus.sub_y), 0);
            end else if (v == 826) begin
                step(0, 826);
                step(336, 826);
                step(1615, 826);
                chk("last_rd_en", 32'(bus.rd_en), 1);
                chk("last_rd_addr", 32'(bus.rd_addr), 3999);
                step(1616, 826);
                chk("last_idx_x", 32'(bus.idx_x), 79);
                chk("last_idx_y", 32'(bus.idx_y), 49);
                chk("last_sub_x", 32'(bus.sub_x), 15);
                chk("last_sub_y", 32'(bus.sub_y), 15);
                chk("h_over_rd_en", 32'(bus.rd_en), 0);
                chk("h_over_rd_addr", 32'(bus.rd_addr), 0);
                step(0, 826);
                chk("h_over_valid", 32'(bus.valid), 0);
                chk("h_over_idx_x", 32'(bus.idx_x), 0);
                chk("h_over_idx_y", 32'(bus.idx_y), 0);
            end else if (v == 827) begin
                step(0, 827);
                step(336, 827);
                chk("v_over_rd_en", 32'(bus.rd_en), 0);
                chk("v_over_rd_addr", 32'(bus.rd_addr), 0);
                step(1616, 827);
                chk("v_over_valid", 32'(bus.valid), 0);
                chk("v_over_idx_y", 32'(bus.idx_y), 0);
                chk("v_over_sub_y", 32'(bus.sub_y), 0);
            end else begin
                run_line(v);
            end
        end
        for (int f = 0; f < 2; f++)
            for (int v = 0; v < 830; v++)
                run_line(v);

        // Vertical jump 100 -> 500 at line start
        for (int v = 0; v <= 100; v++)
            run_line(v);
        step(0, 500);
        exp_serr = 1;
        step(336, 500);
        chk("jump_rd_addr0", 32'(bus.rd_addr), 2320);
        chk("jump_serr", 32'(bus.sync_err), 1);
        step(400, 500);
        chk("jump_rd_addr4", 32'(bus.rd_addr), 2324);
        step(0, 500);
        chk("jump_idx_x", 32'(bus.idx_x), 4);
        chk("jump_idx_y", 32'(bus.idx_y), 29);
        chk("jump_sub_y", 32'(bus.sub_y), 9);
        for (int v = 501; v < 830; v++)
            run_line(v);
        for (int v = 0; v < 27; v++)
            run_line(v);
        step(0, 27);
        chk("serr_held", 32'(bus.sync_err), 1);
        step(336, 27);
        chk("serr_cleared", 32'(bus.sync_err), 0);
        step(1616, 27);

        // Asynchronous reset mid-line at (800,400)
        for (int v = 28; v < 400; v++)
            run_line(v);
        step(0, 400);
        step(336, 400);
        step(800, 400);
        #1;
        rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        auto_chk = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("rst_hold");
        rst_n = 1'b1;
        step(1616, 400);
        step(0, 401);
        exp_serr = 1;
        step(336, 401);
        chk("rst_rd_en", 32'(bus.rd_en), 1);
        chk("rst_rd_addr", 32'(bus.rd_addr), 1840);
        chk("rst_serr1", 32'(bus.sync_err), 1);
        step(337, 401);
        chk("rst_valid", 32'(bus.valid), 1);
        chk("rst_idx_y", 32'(bus.idx_y), 23);
        chk("rst_sub_y", 32'(bus.sub_y), 6);
        chk("rst_serr2", 32'(bus.sync_err), 1);
        auto_chk = 1'b1;
        step(1616, 401);
        for (int v = 402; v < 830; v++)
            run_line(v);
        for (int v = 0; v <= 30; v++)
            run_line(v);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/display_to_matrix_idx.md
# display_to_matrix_idx

Inverse of the matrix-to-display mapper. It takes the live VGA raster position (`h_count`, `v_count`) and produces the 80×50 game-matrix cell under the beam, the pixel offset inside that 16×16 cell, and a linear read address for the matrix RAM. The address is issued one cycle ahead of the cell outputs, so a 1-cycle synchronous RAM returns cell data aligned with them. It sits between the VGA timing generator and the pixel/colour stage.

## Interface
- `H_VISIBLE_START`, 336, first visible horizontal count
- `H_VISIBLE_END`, 1615, last visible horizontal count
- `V_VISIBLE_START`, 27, first visible line
- `V_VISIBLE_END`, 826, last visible line
- `MATRIX_W`, 80, cells per row (row stride of the address)
- `clk`  in  1  pixel clock; one raster position per cycle
- `rst_n`  in  1  reset, asynchronous, active-low
- `h_count`  in  11  horizontal raster counter
- `v_count`  in  10  vertical raster counter
- `rd_en`  out  1  matrix RAM read enable (stage 1)
- `rd_addr`  out  12  `idx_y*80 + idx_x`, range 0..3999 (stage 1)
- `valid`  out  1  beam inside visible area (stage 2)
- `idx_x`  out  7  cell column 0..79 (stage 2)
- `idx_y`  out  6  cell row 0..49 (stage 2)
- `sub_x`  out  4  pixel column inside cell (stage 2)
- `sub_y`  out  4  pixel line inside cell (stage 2)
- `frame_start`  out  1  1-cycle pulse at stage 2 for position (H_VISIBLE_START, V_VISIBLE_START)
- `sync_err`  out  1  sticky; set on a row-tracker mismatch, cleared at next `frame_start`

## Operation
- Visible: `H_VISIBLE_START ≤ h_count ≤ H_VISIBLE_END` and `V_VISIBLE_START ≤ v_count ≤ V_VISIBLE_END`.
- Column is combinational: `hx = h_count − H_VISIBLE_START` (11 bits). `idx_x = hx[10:4]`, `sub_x = hx[3:0]`.
- Row is a sequential tracker. Registers: `row` (6), `sub_y` (4), `row_base` (12). The tracker updates only on cycles where `h_count == H_VISIBLE_START`:
  - If `v_count == V_VISIBLE_START`: `row`, `sub_y`, `row_base` are set to 0.
  - Else, if the line is visible: `sub_y += 1`. On a 15→0 wrap, `row += 1` and `row_base += MATRIX_W`.
  - Consistency check: expected `vy = v_count − V_VISIBLE_START`. If `{row, sub_y}` after the update ≠ `vy[9:0]`, set `sync_err`. Then resync: `row = vy[9:4]`, `sub_y = vy[3:0]`, `row_base = (vy[9:4]<<6) + (vy[9:4]<<4)`. No multiplier is used.
- No line-start update occurs on non-visible lines. The tracker holds its value.
- Address: `rd_addr = row_base + idx_x` (12-bit add, no overflow within range). During the line-start cycle, use the post-update tracker values, computed combinationally.
- Outside the visible area: `rd_en = 0`, `valid = 0`, and `rd_addr`, `idx_*`, `sub_*` are forced to 0.
- `sync_err` set takes priority over its clear when both occur in the same cycle.

## Timing
- Inputs are sampled at cycle n.
- Cycle n+1: `rd_en`, `rd_addr` registered.
- Cycle n+2: `valid`, `idx_x`, `idx_y`, `sub_x`, `sub_y`, `frame_start` registered. RAM data read at n+1 is present at n+2.
- Throughput is one position per cycle, with no stalls.
- Reset (asserted at any time, including mid-frame) clears all outputs and all internal state to 0. Both pipeline stages flush immediately.
- After reset, output is correct from the first line-start seen. A mid-frame first line goes through the resync path and sets `sync_err`. `sync_err` clears at the next frame start.
- Jumps in `h_count` inside a line are tolerated, because the column is stateless. Jumps in `v_count` are corrected at the next line start.

## Structure
- Shared package `vga_matrix_pkg`:
  - Visible-window constants.
  - `MATRIX_W = 80`, `MATRIX_H = 50`, `CELL_SHIFT = 4`.
  - `ADDR_W = 12`.
  - Index width constants (7/6).
- One sub-module: `matrix_row_tracker`, containing `row`, `sub_y`, `row_base`, the check and resync logic, and `sync_err`.
- The top level holds the column decode, address add, and the two pipeline stages.

## Test plan
- Reset, then full frame from (0,0) → at (336,27): n+1 `rd_addr=0`, `rd_en=1`; n+2 `valid=1`, idx (0,0), sub (0,0), `frame_start=1`, `sync_err=0`.
- Position (351,42) in a normal raster → idx (0,0), sub (15,15), `rd_addr=0`. Position (352,43) → idx (1,1), sub (0,0), `rd_addr=81`.
- Position (1615,826) → idx (79,49), sub (15,15), `rd_addr=3999`. Position (1616,826) and (336,827) → `valid=0`, `rd_en=0`, all fields 0.
- Raster jumps from line 100 to line 500 at line start → `sync_err=1`. Outputs show `idx_y=29`, `sub_y=9`, `rd_addr=2320+idx_x`. `sync_err` stays set until the next (336,27), then drops.
- Assert `rst_n` low mid-line at (800,400) for 3 cycles → all outputs 0 asynchronously. Resume at line 401 → `sync_err=1`, `idx_y=23`, `sub_y=6`.
- Random contiguous raster over 3 frames vs a reference model using divide/modulo → zero mismatches, `sync_err=0` after frame 1.
